psc_serial_collector: RTL and testbench
=======================================

# psc_serial_collector

Receive-side counterpart of the parallel/serial converter tile array: gathers 8-bit-per-lane serial beats, rebuilds four words of up to MAX_WORD_LENGTH bits per lane, and presents them as one parallel frame behind a valid/ready handshake. It sits at the destination end of the interconnect, where tile-array serial lanes terminate, and feeds downstream parallel consumers.

## Interface
- MAX_WORD_LENGTH, 32: maximum word width in bits; even, at least 2.
- LANES, 1: number of independent 8-bit serial lanes, all advancing in lockstep.
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame and latches word_length.
- word_length  in  $clog2(MAX_WORD_LENGTH)+1  bits per word for this frame.
- serial_valid  in  1  a serial beat is present on serial_data_in.
- serial_data_in  in  8*LANES  beat; within each lane byte, bits [2k+1:2k] carry word k (k=0..3), LSB-first.
- parallel_valid  out  1  the frame is held on parallel_data_out.
- parallel_ready  in  1  downstream accepts the frame.
- parallel_data_out  out  4*MAX_WORD_LENGTH*LANES  lane g occupies slice g; word k of lane g occupies sub-slice k, each MAX_WORD_LENGTH wide.
- finish  out  1  one-cycle pulse when the frame handshake completes.
- overrun  out  1  sticky flag: a beat arrived while a frame was being held.

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- IDLE: start=1 latches the effective length, clears the beat counter and all shift registers, and moves to COLLECT.
- Effective length L: word_length=0 or word_length>MAX_WORD_LENGTH clamps to MAX_WORD_LENGTH. An odd value is kept as L, but the beat count is ceil(L/2).
- COLLECT: each cycle with serial_valid=1, every word shifts in its 2 bits, LSB-first. Beat n fills bits [2n+1:2n]. Cycles with serial_valid=0 are stalls with no state change.
- When the beat counter reaches ceil(L/2)-1 and that beat is accepted, the FSM moves to HOLD.
- On entry to HOLD, bits at positions L..MAX_WORD_LENGTH-1 of every word are forced to 0. This covers the extra bit when L is odd.
- HOLD: parallel_valid=1 and data stays stable. When parallel_ready=1, finish pulses, the FSM returns to IDLE, and parallel_valid drops the next cycle.
- start in COLLECT: aborts the partial frame, relatches word_length, and restarts from beat 0. No finish pulse.
- start in HOLD: ignored. The held frame is not lost.
- serial_valid=1 in HOLD: the beat is dropped and overrun is set. overrun clears only on reset or on a start accepted in IDLE.
- serial_valid=1 in IDLE without start: the beat is dropped. overrun is not set.
- start and serial_valid in the same IDLE cycle: the start is taken and the beat is dropped. The first data beat arrives the cycle after start.

## Timing
- Reset values: state=IDLE, parallel_valid=0, finish=0, overrun=0, parallel_data_out=0, beat counter=0.
- Reset asserted mid-frame aborts immediately (asynchronous). The first start is honoured on the first clock edge after release.
- Latency: parallel_valid rises on the clock edge that accepts the last beat. The frame is visible the cycle after that beat.
- Minimum frame time is 1 (start) + ceil(L/2) beats + 1 (handshake) cycles, so 18 cycles at L=32.
- parallel_data_out is registered and changes only on entry to HOLD or on reset.
- finish is registered and asserted exactly in the cycle after the accepting parallel_ready edge.

## Configuration
- PSC_SIGN_EXT_EN defined: on entry to HOLD, bits L..MAX_WORD_LENGTH-1 of each word are copied from bit L-1 (two's-complement sign extension).
- PSC_SIGN_EXT_EN undefined: those bits are zero-filled. All other behaviour is identical.

## Structure
- Shared package psc_pkg holds:
  - WORDS_PER_LANE=4 and BITS_PER_BEAT=2;
  - the FSM state enum (IDLE, COLLECT, HOLD);
  - a function that clamps word_length and computes the beat count.
- Sub-module psc_lane_shifter, instantiated once per lane in a generate loop. It contains four MAX_WORD_LENGTH shift registers plus the mask/extend logic.
- The top level owns the FSM, beat counter, handshake and overrun flag.

## Test plan
- Basic frame: LANES=1, L=32, 16 beats of 8'hE4 (word0=0, word1=1, word2=2, word3=3 per beat) → words 0x00000000, 0x55555555, 0xAAAAAAAA, 0xFFFFFFFF; parallel_valid is high after beat 16; finish pulses once after parallel_ready.
- Odd length: L=5, 3 beats of 8'hFF → each word reads 0x1F with the macro undefined, 0xFFFFFFFF with PSC_SIGN_EXT_EN.
- Stalls and backpressure: serial_valid toggled 1/0 across the frame, then parallel_ready held 0 for 5 cycles → data unchanged, parallel_valid stays high, finish fires once.
- Overrun: a beat during HOLD → overrun=1, output data unchanged; the next start accepted in IDLE clears overrun.
- Restart and clamp: start mid-COLLECT with word_length=0 → the frame restarts as L=32 and needs a full 16 beats; no finish for the aborted frame.
- Reset mid-frame: reset low at beat 7 → all outputs return to their reset values immediately; a new frame after release completes correctly.

Source files
------------

// File: rtl/psc_pkg.sv
// rtl/psc_pkg.sv - shared constants, FSM state type and length clamp helper for the serial collector
package psc_pkg;

    localparam int WORDS_PER_LANE = 4;
    localparam int BITS_PER_BEAT  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } psc_state_e;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] beats;
    } psc_len_t;

    // Zero or oversize lengths mean "full word"; odd lengths round the beat count up.
    function automatic psc_len_t psc_clamp_len(input int unsigned wl, input int unsigned max_wl);
        psc_len_t    r;
        int unsigned l;
        l       = (wl == 0 || wl > max_wl) ? max_wl : wl;
        r.len   = 16'(l);
        r.beats = 16'((l + BITS_PER_BEAT - 1) / BITS_PER_BEAT);
        return r;
    endfunction

endpackage

// File: rtl/psc_lane_shifter.sv
// rtl/psc_lane_shifter.sv - per-lane word assembly and tail masking; PSC_SIGN_EXT_EN selects sign extension
module psc_lane_shifter
    import psc_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clear,
    input  logic                                      shift_en,
    input  logic                                      finalize,
    input  logic [$clog2(MAX_WORD_LENGTH)-1:0]        beat_idx,
    input  logic [$clog2(MAX_WORD_LENGTH):0]          len,
    input  logic [7:0]                                beat_bits,
    output logic [WORDS_PER_LANE*MAX_WORD_LENGTH-1:0] data_out
);

    localparam int BW  = $clog2(MAX_WORD_LENGTH);
    localparam int WLW = BW + 1;

    logic [MAX_WORD_LENGTH-1:0]                sr_q [WORDS_PER_LANE];
    logic [MAX_WORD_LENGTH-1:0]                sr_d [WORDS_PER_LANE];
    logic [WORDS_PER_LANE*MAX_WORD_LENGTH-1:0] out_q;
    logic [WORDS_PER_LANE*MAX_WORD_LENGTH-1:0] out_d;
    logic [BW-1:0]                             bit_base;
    logic [BW-1:0]                             top_bit;
    logic                                      fill;

    assign bit_base = BW'({beat_idx, 1'b0});
    assign top_bit  = BW'(len - 1'b1);

    always_comb begin
        for (int k = 0; k < WORDS_PER_LANE; k++) begin
            sr_d[k] = sr_q[k];
            if (clear) begin
                sr_d[k] = '0;
            end else if (shift_en) begin
                sr_d[k][bit_base +: BITS_PER_BEAT] = beat_bits[k*BITS_PER_BEAT +: BITS_PER_BEAT];
            end
        end
    end

    // The output image is built from the post-beat contents so the final beat lands in the frame.
    always_comb begin
        out_d = out_q;
        fill  = 1'b0;
        if (finalize) begin
            for (int k = 0; k < WORDS_PER_LANE; k++) begin
`ifdef PSC_SIGN_EXT_EN
                fill = sr_d[k][top_bit];
`else
                fill = 1'b0;
`endif
                for (int i = 0; i < MAX_WORD_LENGTH; i++) begin
                    out_d[k*MAX_WORD_LENGTH + i] = (WLW'(i) >= len) ? fill : sr_d[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < WORDS_PER_LANE; k++) sr_q[k] <= '0;
            out_q <= '0;
        end else begin
            for (int k = 0; k < WORDS_PER_LANE; k++) sr_q[k] <= sr_d[k];
            out_q <= out_d;
        end
    end

    assign data_out = out_q;

endmodule

// File: rtl/psc_serial_collector.sv
// rtl/psc_serial_collector.sv - serial-to-parallel frame collector top: FSM, beat counter, handshake, overrun
module psc_serial_collector
    import psc_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int LANES           = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic [$clog2(MAX_WORD_LENGTH):0]                word_length,
    input  logic                                            serial_valid,
    input  logic [8*LANES-1:0]                              serial_data_in,
    output logic                                            parallel_valid,
    input  logic                                            parallel_ready,
    output logic [WORDS_PER_LANE*MAX_WORD_LENGTH*LANES-1:0] parallel_data_out,
    output logic                                            finish,
    output logic                                            overrun
);

    localparam int BW  = $clog2(MAX_WORD_LENGTH);
    localparam int WLW = BW + 1;
    localparam int LW  = WORDS_PER_LANE * MAX_WORD_LENGTH;

    psc_state_e     state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [BW-1:0]  last_q, last_d;
    logic [WLW-1:0] len_q, len_d;
    logic           pvalid_q, pvalid_d;
    logic           finish_q, finish_d;
    logic           overrun_q, overrun_d;
    logic           clear, shift_en, finalize;
    psc_len_t       eff;

    always_comb begin
        eff       = psc_clamp_len(32'(word_length), MAX_WORD_LENGTH);
        state_d   = state_q;
        beat_d    = beat_q;
        last_d    = last_q;
        len_d     = len_q;
        pvalid_d  = pvalid_q;
        finish_d  = 1'b0;
        overrun_d = overrun_q;
        clear     = 1'b0;
        shift_en  = 1'b0;
        finalize  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = WLW'(eff.len);
                    last_d    = BW'(eff.beats - 16'd1);
                    beat_d    = '0;
                    clear     = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                // A start here abandons the partial frame without signalling finish.
                if (start) begin
                    len_d  = WLW'(eff.len);
                    last_d = BW'(eff.beats - 16'd1);
                    beat_d = '0;
                    clear  = 1'b1;
                end else if (serial_valid) begin
                    shift_en = 1'b1;
                    if (beat_q == last_q) begin
                        finalize = 1'b1;
                        pvalid_d = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (serial_valid) overrun_d = 1'b1;
                if (parallel_ready) begin
                    finish_d = 1'b1;
                    pvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            last_q    <= '0;
            len_q     <= WLW'(MAX_WORD_LENGTH);
            pvalid_q  <= 1'b0;
            finish_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            len_q     <= len_d;
            pvalid_q  <= pvalid_d;
            finish_q  <= finish_d;
            overrun_q <= overrun_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psc_lane_shifter #(
            .MAX_WORD_LENGTH(MAX_WORD_LENGTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .shift_en (shift_en),
            .finalize (finalize),
            .beat_idx (beat_q),
            .len      (len_q),
            .beat_bits(serial_data_in[g*8 +: 8]),
            .data_out (parallel_data_out[g*LW +: LW])
        );
    end

    assign parallel_valid = pvalid_q;
    assign finish         = finish_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_psc_serial_collector.sv
// tb/tb_psc_serial_collector.sv - scoreboard bench for psc_serial_collector; honours PSC_SIGN_EXT_EN
module tb_psc_serial_collector;

    localparam int MAXW  = 32;
    localparam int LANES = 1;
    localparam int DW    = 4 * MAXW * LANES;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    word_length;
    logic          serial_valid;
    logic [7:0]    serial_data_in;
    logic          parallel_valid;
    logic          parallel_ready;
    logic [DW-1:0] parallel_data_out;
    logic          finish;
    logic          overrun;

    int            checks = 0;
    int            errors = 0;
    int            fin_cnt = 0;
    int            n_coll = 0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    beats[$];
    logic [DW-1:0] snap;

    always #5 clk = ~clk;

    psc_serial_collector #(.MAX_WORD_LENGTH(MAXW), .LANES(LANES)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .word_length      (word_length),
        .serial_valid     (serial_valid),
        .serial_data_in   (serial_data_in),
        .parallel_valid   (parallel_valid),
        .parallel_ready   (parallel_ready),
        .parallel_data_out(parallel_data_out),
        .finish           (finish),
        .overrun          (overrun)
    );

    always @(posedge clk) if (reset && finish) fin_cnt++;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int wl);
        return (wl == 0 || wl > MAXW) ? MAXW : wl;
    endfunction

    function automatic logic [DW-1:0] model(input int len);
        logic [DW-1:0]   r;
        logic [MAXW-1:0] w;
        logic [7:0]      b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            w = '0;
            for (int n = 0; n < beats.size(); n++) begin
                b = beats[n];
                w[2*n]   = b[2*k];
                w[2*n+1] = b[2*k+1];
            end
            for (int i = len; i < MAXW; i++) begin
`ifdef PSC_SIGN_EXT_EN
                w[i] = w[len-1];
`else
                w[i] = 1'b0;
`endif
            end
            r[k*MAXW +: MAXW] = w;
        end
        return r;
    endfunction

    task automatic do_start(input int wl, input bit junk_beat);
        start          = 1'b1;
        word_length    = 6'(wl);
        serial_valid   = junk_beat;
        serial_data_in = 8'h5A;
        tick();
        start        = 1'b0;
        serial_valid = 1'b0;
        beats.delete();
    endtask

    task automatic send_beat(input logic [7:0] b);
        serial_valid   = 1'b1;
        serial_data_in = b;
        beats.push_back(b);
        tick();
        serial_valid = 1'b0;
    endtask

    task automatic send_frame(input int wl, input logic [7:0] pat, input bit rnd, input bit stall, input bit junk);
        int n;
        n = (clamp(wl) + 1) / 2;
        do_start(wl, junk);
        for (int i = 0; i < n; i++) begin
            send_beat(rnd ? 8'($urandom) : pat);
            if (i == n - 1) exp_q.push_back(model(clamp(wl)));
            check($sformatf("pvalid_beat%0d", i), DW'(parallel_valid), DW'(i == n - 1));
            if (stall && i < n - 1) begin
                tick();
                check("pvalid_stall", DW'(parallel_valid), '0);
            end
        end
    endtask

    task automatic collect(input int delay);
        int            waited;
        logic [DW-1:0] exp;
        waited = 0;
        while (!parallel_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("pvalid_wait", DW'(parallel_valid), DW'(1));
        check("sb_nonempty", DW'(exp_q.size() != 0), DW'(1));
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int d = 0; d < delay; d++) begin
            parallel_ready = 1'b0;
            tick();
            check("bp_data", parallel_data_out, exp);
            check("bp_pvalid", DW'(parallel_valid), DW'(1));
            check("bp_finish", DW'(finish), '0);
        end
        check("frame_data", parallel_data_out, exp);
        parallel_ready = 1'b1;
        tick();
        parallel_ready = 1'b0;
        n_coll++;
        check("finish_pulse", DW'(finish), DW'(1));
        check("pvalid_drop", DW'(parallel_valid), '0);
        tick();
        check("finish_single", DW'(finish), '0);
    endtask

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        word_length    = '0;
        serial_valid   = 1'b0;
        serial_data_in = '0;
        parallel_ready = 1'b0;
        tick();
        check("rst_pvalid", DW'(parallel_valid), '0);
        check("rst_finish", DW'(finish), '0);
        check("rst_overrun", DW'(overrun), '0);
        check("rst_data", parallel_data_out, '0);
        reset = 1'b1;
        tick();

        // Idle beat without start is dropped and does not flag overrun.
        serial_valid = 1'b1;
        serial_data_in = 8'hFF;
        tick();
        serial_valid = 1'b0;
        check("idle_beat_overrun", DW'(overrun), '0);
        check("idle_beat_pvalid", DW'(parallel_valid), '0);

        send_frame(32, 8'hE4, 1'b0, 1'b0, 1'b0);
        check("basic_const", parallel_data_out, 128'hFFFFFFFF_AAAAAAAA_55555555_00000000);
        collect(0);

        send_frame(5, 8'hFF, 1'b0, 1'b0, 1'b1);
`ifdef PSC_SIGN_EXT_EN
        check("odd_const", parallel_data_out, {4{32'hFFFFFFFF}});
`else
        check("odd_const", parallel_data_out, {4{32'h0000001F}});
`endif
        collect(0);

        send_frame(12, 8'h00, 1'b1, 1'b1, 1'b0);
        collect(5);

        send_frame(40, 8'h00, 1'b1, 1'b0, 1'b0);
        snap = parallel_data_out;
        serial_valid = 1'b1;
        serial_data_in = 8'hC3;
        tick();
        serial_valid = 1'b0;
        check("overrun_set", DW'(overrun), DW'(1));
        check("overrun_data", parallel_data_out, snap);
        start = 1'b1;
        word_length = 6'd4;
        tick();
        start = 1'b0;
        check("hold_start_ignored", DW'(parallel_valid), DW'(1));
        collect(0);
        check("overrun_sticky", DW'(overrun), DW'(1));

        do_start(8, 1'b0);
        check("overrun_clear", DW'(overrun), '0);
        send_beat(8'h11);
        send_beat(8'h22);
        send_frame(0, 8'h00, 1'b1, 1'b0, 1'b0);
        collect(0);

        do_start(32, 1'b0);
        for (int i = 0; i < 7; i++) send_beat(8'($urandom));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pvalid", DW'(parallel_valid), '0);
        check("mid_rst_finish", DW'(finish), '0);
        check("mid_rst_overrun", DW'(overrun), '0);
        check("mid_rst_data", parallel_data_out, '0);
        reset = 1'b1;
        tick();
        send_frame(31, 8'h00, 1'b1, 1'b0, 1'b0);
        collect(2);

        check("finish_count", DW'(fin_cnt), DW'(n_coll));
        check("sb_drained", DW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
